// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external combinational multiplier with a registered valid/ready response.
module mult_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 4,
  parameter int IDW   = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [W-1:0]      mul_x,
  output logic [W-1:0]      mul_y,
  input  logic [2*W-1:0]    mul_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_prod,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t state, state_n;
  logic [IDW-1:0] ptr, g;
  logic [W-1:0] op_x, op_y;
  logic found;
  int idx;
  // Scan from the highest offset down so the entry nearest ptr is the last to win.
  always_comb begin
    found = 1'b0;
    g = '0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        g = IDW'(idx);
      end
    end
  end
  always_comb begin
    state_n = (state == IDLE) ? (found ? CALC : IDLE) :
              (state == CALC) ? RESP : (rsp_ready ? IDLE : RESP);
  end
  assign req_ready = (state == IDLE && found && !rst) ? NREQ'(1) << g : '0;
  assign busy = state != IDLE;
  assign mul_x = op_x;
  assign mul_y = op_y;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      op_x <= '0;
      op_y <= '0;
      rsp_id <= '0;
      rsp_prod <= '0;
      rsp_valid <= 1'b0;
      txn_count <= '0;
    end else if (state == IDLE && found) begin
      op_x <= req_x[g*W +: W];
      op_y <= req_y[g*W +: W];
      rsp_id <= g;
    end else if (state == CALC) begin
      rsp_prod <= mul_o;
      rsp_valid <= 1'b1;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
      txn_count <= txn_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed checks of arbitration, latency, backpressure, reset and counter wrap.
module tb_mult_share_arbiter;
  localparam int NREQ = 4, W = 4, IDW = 2, CNT_W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*W-1:0] req_x, req_y;
  logic [W-1:0] mul_x, mul_y;
  logic [2*W-1:0] mul_o, rsp_prod;
  logic rsp_valid, rsp_ready, busy;
  logic [IDW-1:0] rsp_id;
  logic [CNT_W-1:0] txn_count;
  int errors = 0, checks = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_p;

  always #5 clk = ~clk;
  // Stand-in for the external combinational multiplier.
  assign mul_o = 8'(mul_x) * 8'(mul_y);

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .mul_x(mul_x), .mul_y(mul_y), .mul_o(mul_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_prod(rsp_prod), .busy(busy), .txn_count(txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input int i, input logic [3:0] x, input logic [3:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txn_count", 32'(txn_count), 0);
    chk("rst_rsp_prod", 32'(rsp_prod), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_mul_x", 32'(mul_x), 0);
    rst = 1'b0;
    // Single request: requester 1, 3*5
    setop(1, 4'd3, 4'd5);
    req_valid = 4'b0010;
    #1;
    chk("single_ready", 32'(req_ready), 'b0010);
    chk("single_idle_busy", 32'(busy), 0);
    step();
    req_valid = '0;
    chk("single_calc_valid", 32'(rsp_valid), 0);
    chk("single_calc_busy", 32'(busy), 1);
    chk("single_mul_x", 32'(mul_x), 3);
    chk("single_mul_y", 32'(mul_y), 5);
    chk("single_calc_ready", 32'(req_ready), 0);
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_prod", 32'(rsp_prod), 'h0F);
    chk("single_rsp_id", 32'(rsp_id), 1);
    rsp_ready = 1'b1;
    step();
    chk("single_rsp_drop", 32'(rsp_valid), 0);
    chk("single_txn", 32'(txn_count), 1);
    // Boundary: 15*15 then 0*9 from requester 0, back to back
    setop(0, 4'd15, 4'd15);
    req_valid = 4'b0001;
    #1;
    chk("bnd_ready_a", 32'(req_ready), 'b0001);
    step();
    setop(0, 4'd0, 4'd9);
    chk("bnd_calc_ready", 32'(req_ready), 0);
    chk("bnd_mul_x", 32'(mul_x), 15);
    step();
    chk("bnd_prod_max", 32'(rsp_prod), 'hE1);
    chk("bnd_id_a", 32'(rsp_id), 0);
    chk("bnd_resp_ready", 32'(req_ready), 0);
    step();
    chk("bnd_ready_b", 32'(req_ready), 'b0001);
    step();
    req_valid = '0;
    step();
    chk("bnd_prod_zero", 32'(rsp_prod), 0);
    chk("bnd_valid_b", 32'(rsp_valid), 1);
    step();
    chk("bnd_txn", 32'(txn_count), 3);
    // Round robin: all four valid from reset, x=i+1, y=2
    req_valid = '0;
    do_reset();
    for (int i = 0; i < NREQ; i++) setop(i, 4'(i + 1), 4'd2);
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) begin
      chk("rr_ready", 32'(req_ready), 32'(1) << (t % 4));
      step();
      chk("rr_calc_ready", 32'(req_ready), 0);
      step();
      chk("rr_valid", 32'(rsp_valid), 1);
      chk("rr_id", 32'(rsp_id), t % 4);
      chk("rr_prod", 32'(rsp_prod), 2 * ((t % 4) + 1));
      chk("rr_resp_ready", 32'(req_ready), 0);
      step();
    end
    chk("rr_txn", 32'(txn_count), 5);
    // Backpressure: requester 1 served while 2 waits, consumer stalls
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    #1;
    chk("bp_ready1", 32'(req_ready), 'b0010);
    step();
    req_valid = 4'b0100;
    step();
    chk("bp_valid0", 32'(rsp_valid), 1);
    chk("bp_prod0", 32'(rsp_prod), 4);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_prod", 32'(rsp_prod), 4);
      chk("bp_hold_id", 32'(rsp_id), 1);
      chk("bp_hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_valid_drop", 32'(rsp_valid), 0);
    chk("bp_ready2", 32'(req_ready), 'b0100);
    step();
    req_valid = '0;
    step();
    chk("bp_prod2", 32'(rsp_prod), 6);
    chk("bp_id2", 32'(rsp_id), 2);
    rsp_ready = 1'b1;
    step();
    chk("bp_txn", 32'(txn_count), 7);
    // Reset during CALC for requester 3 (4*2)
    req_valid = 4'b1000;
    #1;
    chk("rc_ready3", 32'(req_ready), 'b1000);
    step();
    chk("rc_busy_calc", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rc_rst_valid", 32'(rsp_valid), 0);
    chk("rc_rst_busy", 32'(busy), 0);
    chk("rc_rst_txn", 32'(txn_count), 0);
    chk("rc_rst_ready", 32'(req_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("rc_regrant", 32'(req_ready), 'b1000);
    step();
    req_valid = '0;
    step();
    chk("rc_valid", 32'(rsp_valid), 1);
    chk("rc_prod", 32'(rsp_prod), 8);
    chk("rc_id", 32'(rsp_id), 3);
    step();
    chk("rc_txn", 32'(txn_count), 1);
    // Counter wrap: 256 back-to-back transactions with a scoreboard
    do_reset();
    for (int i = 0; i < NREQ; i++) setop(i, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int t = 0; t < 256; t++) begin
      chk("wr_ready", 32'(req_ready), 32'(1) << (t % 4));
      sb.push_back(8'(req_x[(t % 4)*W +: W]) * 8'(req_y[(t % 4)*W +: W]));
      step();
      setop(t % 4, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      step();
      chk("wr_valid", 32'(rsp_valid), 1);
      chk("wr_id", 32'(rsp_id), t % 4);
      if (sb.size() == 0) begin
        chk("wr_sb_nonempty", 0, 1);
      end else begin
        exp_p = sb.pop_front();
        chk("wr_prod", 32'(rsp_prod), 32'(exp_p));
      end
      step();
      chk("wr_txn", 32'(txn_count), (t + 1) % 256);
    end
    chk("wr_sb_empty", sb.size(), 0);
    chk("wr_txn_final", 32'(txn_count), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
